// File: rtl/pipeline_debug_ctrl.sv
// Debug controller for a pipelined CPU: receives a byte command stream, loads
// instruction words into the pipeline's instruction memory, and runs or single-steps it.
module pipeline_debug_ctrl #(
  parameter int NB_DATA   = 32,
  parameter int NB_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_rx_valid,
  input  logic [7:0]           i_rx_data,
  output logic                 o_rx_ready,
  input  logic                 i_program_end,
  output logic                 o_we_IF,
  output logic [NB_DATA-1:0]   o_instruction_data,
  output logic                 o_halt,
  output logic                 o_pipe_rst,
  output logic                 o_done,
  output logic                 o_cmd_err,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int IDX_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  localparam logic [7:0] CMD_LOAD     = 8'h4C;
  localparam logic [7:0] CMD_CONTINUE = 8'h43;
  localparam logic [7:0] CMD_STEP     = 8'h53;
  localparam logic [7:0] CMD_RESET    = 8'h52;

  typedef enum logic [2:0] {
    IDLE, LOAD_CNT, LOAD_BYTE, WRITE, RUN, STEP, DONE
  } state_t;

  state_t               state, next_state;
  logic                 accept, cmd_phase, load_accept, last_byte, known_cmd;
  logic                 rx_ready_d, we_d, halt_d, done_d, pipe_rst_d, cmd_err_d;
  logic [7:0]           word_cnt;
  logic [IDX_W-1:0]     byte_idx;
  logic [NB_DATA-1:0]   asm_next;

  assign accept      = i_rx_valid && o_rx_ready;
  assign cmd_phase   = (state == IDLE) || (state == DONE);
  assign load_accept = (state == LOAD_BYTE) && accept;
  assign last_byte   = (byte_idx == IDX_W'(NB_BYTES - 1));
  assign known_cmd   = i_rx_data inside {CMD_LOAD, CMD_CONTINUE, CMD_STEP, CMD_RESET};

  // Only the leading bytes of a word need storage; the final byte comes straight off the bus.
  if (NB_BYTES > 1) begin : g_multi
    logic [NB_DATA-9:0] head;
    always_ff @(posedge clk) begin
      if (i_rst)            head <= '0;
      else if (load_accept) head <= asm_next[NB_DATA-9:0];
    end
    assign asm_next = {head, i_rx_data};
  end else begin : g_single
    assign asm_next = i_rx_data;
  end

  // State register; every output is registered from the decoded next state.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_rx_ready <= 1'b0;
      o_we_IF    <= 1'b0;
      o_halt     <= 1'b1;
      o_pipe_rst <= 1'b0;
      o_done     <= 1'b0;
      o_cmd_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= next_state;
      o_rx_ready <= rx_ready_d;
      o_we_IF    <= we_d;
      o_halt     <= halt_d;
      o_pipe_rst <= pipe_rst_d;
      o_done     <= done_d;
      o_cmd_err  <= cmd_err_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          unique case (i_rx_data)
            CMD_LOAD:     next_state = LOAD_CNT;
            CMD_CONTINUE: next_state = RUN;
            CMD_STEP:     next_state = STEP;
            default:      next_state = IDLE;
          endcase
        end
      end
      LOAD_CNT:  if (accept) next_state = (i_rx_data == 8'd0) ? IDLE : LOAD_BYTE;
      LOAD_BYTE: if (accept && last_byte) next_state = WRITE;
      WRITE:     next_state = (word_cnt > 8'd1) ? LOAD_BYTE : IDLE;
      RUN:       if (i_program_end) next_state = DONE;
      STEP:      next_state = i_program_end ? DONE : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    rx_ready_d = next_state inside {IDLE, LOAD_CNT, LOAD_BYTE, DONE};
    we_d       = (next_state == WRITE);
    halt_d     = !(next_state inside {RUN, STEP});
    done_d     = (next_state == DONE);
    pipe_rst_d = cmd_phase && accept && (i_rx_data == CMD_RESET);
    cmd_err_d  = cmd_phase && accept && !known_cmd;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      word_cnt           <= '0;
      byte_idx           <= '0;
      o_instruction_data <= '0;
      o_cycle_count      <= '0;
    end else begin
      if ((state == LOAD_CNT) && accept) begin
        word_cnt <= i_rx_data;
        byte_idx <= '0;
      end
      if (load_accept) begin
        byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
        if (last_byte) o_instruction_data <= asm_next;
      end
      if (state == WRITE) word_cnt <= word_cnt - 8'd1;

      if (pipe_rst_d)
        o_cycle_count <= '0;
      else if (!o_halt && (o_cycle_count != '1))
        o_cycle_count <= o_cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed bench for pipeline_debug_ctrl: load, run, step, error and reset scenarios.
module tb_pipeline_debug_ctrl;

  localparam int NB_DATA   = 32;
  localparam int NB_CYCLES = 4;

  logic                 clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic                 i_rx_valid = 1'b0;
  logic [7:0]           i_rx_data = 8'h00;
  logic                 o_rx_ready;
  logic                 i_program_end = 1'b0;
  logic                 o_we_IF;
  logic [NB_DATA-1:0]   o_instruction_data;
  logic                 o_halt, o_pipe_rst, o_done, o_cmd_err;
  logic [NB_CYCLES-1:0] o_cycle_count;

  int checks = 0;
  int failures = 0;

  // Pulse and window counters sampled mid-cycle.
  int we_pulses = 0, halt_low = 0, rst_pulses = 0, err_pulses = 0;
  logic [NB_DATA-1:0] words[$];

  pipeline_debug_ctrl #(.NB_DATA(NB_DATA), .NB_CYCLES(NB_CYCLES)) dut (
    .clk(clk), .i_rst(i_rst), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_rx_ready(o_rx_ready), .i_program_end(i_program_end), .o_we_IF(o_we_IF),
    .o_instruction_data(o_instruction_data), .o_halt(o_halt), .o_pipe_rst(o_pipe_rst),
    .o_done(o_done), .o_cmd_err(o_cmd_err), .o_cycle_count(o_cycle_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_we_IF) begin
      we_pulses++;
      words.push_back(o_instruction_data);
    end
    if (!o_halt)    halt_low++;
    if (o_pipe_rst) rst_pulses++;
    if (o_cmd_err)  err_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    while (!o_rx_ready && n < 50) begin
      tick(1);
      n++;
    end
    checks++;
    if (!o_rx_ready) begin
      failures++;
      $display("FAIL send_timeout byte=%02h rx_ready=%0b expected 1", b, o_rx_ready);
    end else begin
      tick(1);
    end
    i_rx_valid = 1'b0;
    i_rx_data  = 8'hXX;
    tick(gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (o_halt !== 1'b1 || o_we_IF !== 1'b0 || o_pipe_rst !== 1'b0 || o_done !== 1'b0 ||
        o_cmd_err !== 1'b0 || o_cycle_count !== '0 || o_instruction_data !== '0 ||
        o_rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s halt=%b we=%b prst=%b done=%b err=%b cnt=%0d data=%h rdy=%b expected 1,0,0,0,0,0,0,0",
               tag, o_halt, o_we_IF, o_pipe_rst, o_done, o_cmd_err, o_cycle_count,
               o_instruction_data, o_rx_ready);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick(2);
    check_reset_outputs("reset_state");
    i_rst = 1'b0;
    tick(1);
    checks++;
    if (o_rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b expected 1", o_rx_ready);
    end
  endtask

  task automatic test_load_single();
    int w0 = we_pulses;
    send_byte(8'h4C, 0); send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'h22, 0); send_byte(8'h18, 0); send_byte(8'h20, 0);
    tick(3);
    checks++;
    if (we_pulses - w0 !== 1 || words[words.size()-1] !== 32'h0022_1820) begin
      failures++;
      $display("FAIL load_single pulses=%0d word=%h expected 1 00221820",
               we_pulses - w0, words[words.size()-1]);
    end
    checks++;
    if (o_halt !== 1'b1 || o_rx_ready !== 1'b1 || o_we_IF !== 1'b0) begin
      failures++;
      $display("FAIL load_single_idle halt=%b rdy=%b we=%b expected 1 1 0", o_halt, o_rx_ready, o_we_IF);
    end
  endtask

  task automatic test_load_gaps();
    int w0 = we_pulses;
    logic [7:0] bytes[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_byte(8'h4C, 3); send_byte(8'h02, 3);
    for (int i = 0; i < 8; i++) send_byte(bytes[i], 3);
    tick(3);
    checks++;
    if (we_pulses - w0 !== 2) begin
      failures++;
      $display("FAIL load_gaps_pulses got=%0d expected 2", we_pulses - w0);
    end else begin
      checks++;
      if (words[words.size()-2] !== 32'h1122_3344 || words[words.size()-1] !== 32'h5566_7788) begin
        failures++;
        $display("FAIL load_gaps_words got=%h %h expected 11223344 55667788",
                 words[words.size()-2], words[words.size()-1]);
      end
    end
  endtask

  task automatic test_run();
    int h0;
    i_program_end = 1'b1;  // ignored while idle
    tick(3);
    i_program_end = 1'b0;
    checks++;
    if (o_done !== 1'b0 || o_halt !== 1'b1) begin
      failures++;
      $display("FAIL end_ignored_idle done=%b halt=%b expected 0 1", o_done, o_halt);
    end
    send_byte(8'h52, 1);
    h0 = halt_low;
    send_byte(8'h43, 0);
    tick(10);
    i_program_end = 1'b1;
    tick(1);
    i_program_end = 1'b0;
    tick(3);
    checks++;
    if (halt_low - h0 !== 11 || o_cycle_count !== 4'd11 || o_done !== 1'b1 || o_halt !== 1'b1) begin
      failures++;
      $display("FAIL run halt_low=%0d cnt=%0d done=%b halt=%b expected 11 11 1 1",
               halt_low - h0, o_cycle_count, o_done, o_halt);
    end
  endtask

  task automatic test_step();
    int h0, r0;
    send_byte(8'h52, 1);
    h0 = halt_low;
    for (int i = 0; i < 3; i++) send_byte(8'h53, 0);
    tick(2);
    checks++;
    if (halt_low - h0 !== 3 || o_cycle_count !== 4'd3 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL step3 halt_low=%0d cnt=%0d done=%b expected 3 3 0",
               halt_low - h0, o_cycle_count, o_done);
    end
    send_byte(8'h53, 0);
    i_program_end = 1'b1;
    tick(1);
    i_program_end = 1'b0;
    tick(1);
    checks++;
    if (o_done !== 1'b1 || o_cycle_count !== 4'd4) begin
      failures++;
      $display("FAIL step_end done=%b cnt=%0d expected 1 4", o_done, o_cycle_count);
    end
    r0 = rst_pulses;
    send_byte(8'h52, 0);
    checks++;
    if (o_pipe_rst !== 1'b1 || o_cycle_count !== '0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL step_reset_cmd prst=%b cnt=%0d done=%b expected 1 0 0",
               o_pipe_rst, o_cycle_count, o_done);
    end
    tick(2);
    checks++;
    if (rst_pulses - r0 !== 1) begin
      failures++;
      $display("FAIL pipe_rst_width got=%0d expected 1", rst_pulses - r0);
    end
  endtask

  task automatic test_saturate();
    send_byte(8'h52, 1);
    send_byte(8'h43, 20);
    i_program_end = 1'b1;
    tick(1);
    i_program_end = 1'b0;
    tick(1);
    checks++;
    if (o_cycle_count !== 4'hF || o_done !== 1'b1) begin
      failures++;
      $display("FAIL saturate cnt=%0d done=%b expected 15 1", o_cycle_count, o_done);
    end
  endtask

  task automatic test_error_zero();
    int e0 = err_pulses;
    int w0 = we_pulses;
    send_byte(8'h7A, 0);
    checks++;
    if (o_cmd_err !== 1'b1) begin
      failures++;
      $display("FAIL cmd_err_pulse got=%b expected 1", o_cmd_err);
    end
    tick(2);
    checks++;
    if (err_pulses - e0 !== 1 || o_cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL cmd_err_width pulses=%0d now=%b expected 1 0", err_pulses - e0, o_cmd_err);
    end
    send_byte(8'h4C, 0); send_byte(8'h00, 3);
    checks++;
    if (we_pulses - w0 !== 0 || o_rx_ready !== 1'b1 || o_halt !== 1'b1) begin
      failures++;
      $display("FAIL zero_count we=%0d rdy=%b halt=%b expected 0 1 1", we_pulses - w0, o_rx_ready, o_halt);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    send_byte(8'h4C, 0); send_byte(8'h01, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    i_rst = 1'b1;
    tick(1);
    check_reset_outputs("reset_mid_load");
    i_rst = 1'b0;
    tick(1);
    send_byte(8'h43, 3);
    i_rst = 1'b1;
    tick(1);
    check_reset_outputs("reset_mid_run");
    i_rst = 1'b0;
    tick(1);
    w0 = we_pulses;
    send_byte(8'h4C, 0); send_byte(8'h01, 0);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    tick(3);
    checks++;
    if (we_pulses - w0 !== 1 || words[words.size()-1] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL reset_then_load pulses=%0d word=%h expected 1 deadbeef",
               we_pulses - w0, words[words.size()-1]);
    end
  endtask

  initial begin
    test_reset();
    test_load_single();
    test_load_gaps();
    test_run();
    test_step();
    test_saturate();
    test_error_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
